// File: rtl/pong_match_controller.sv
// pong_match_controller: match FSM with scores, match clock and winner decision; optional PONG_WIN_BY_TWO_EN
//   in : clk, reset (async, active-high), tick_1hz, start, pause_req, mode_timed, point_p1, point_p2
//   out: scoreP1, scoreP2, timer_minutes, timer_seconds, game_active, game_over, winner, game_state
module pong_match_controller #(
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 7,
  parameter int MATCH_SECONDS = 120,
  parameter int SERVE_TICKS   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic               pause_req,
  input  logic               mode_timed,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [SCORE_W-1:0] scoreP1,
  output logic [SCORE_W-1:0] scoreP2,
  output logic [5:0]         timer_minutes,
  output logic [5:0]         timer_seconds,
  output logic               game_active,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [2:0]         game_state
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, PAUSED, OVER} state_t;
  localparam int CW = SERVE_TICKS > 1 ? $clog2(SERVE_TICKS) : 1;
  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [5:0] LOAD_MIN = 6'(MATCH_SECONDS / 60);
  localparam logic [5:0] LOAD_SEC = 6'(MATCH_SECONDS % 60);
  state_t state, state_d;
  logic mode, pt, tk, sat_hit, score_win, timeout, over_ev, at_max, active_d, over_d;
  logic [CW-1:0] serve_cnt;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic [5:0] min_n, sec_n;
  logic [1:0] winner_d;
  // pause_req wins over a same-cycle tick or point while in PLAY
  assign pt = state == PLAY && !pause_req && (point_p1 ^ point_p2);
  assign tk = state == PLAY && !pause_req && tick_1hz;
  assign s1_n = pt && point_p1 && scoreP1 != SMAX ? scoreP1 + 1'b1 : scoreP1;
  assign s2_n = pt && point_p2 && scoreP2 != SMAX ? scoreP2 + 1'b1 : scoreP2;
  // a score already pinned at max means the next point ends the match in any mode
  assign sat_hit = scoreP1 == SMAX || scoreP2 == SMAX;
`ifdef PONG_WIN_BY_TWO_EN
  assign score_win = !mode && ((s1_n >= WIN && {1'b0, s1_n} >= {1'b0, s2_n} + (SCORE_W+1)'(2)) ||
                               (s2_n >= WIN && {1'b0, s2_n} >= {1'b0, s1_n} + (SCORE_W+1)'(2)));
`else
  assign score_win = !mode && (s1_n >= WIN || s2_n >= WIN);
`endif
  assign timeout = tk && mode && timer_minutes == 6'd0 && timer_seconds == 6'd1;
  assign over_ev = (pt && (score_win || sat_hit)) || timeout;
  // the 6-bit minute port tops out at 63, so elapsed time holds at 63:59
  assign at_max = timer_minutes == 6'd63 && timer_seconds == 6'd59;
  assign sec_n = mode ? (timer_seconds == 6'd0 ? 6'd59 : timer_seconds - 6'd1)
                      : (at_max ? timer_seconds : timer_seconds == 6'd59 ? 6'd0 : timer_seconds + 6'd1);
  assign min_n = mode ? (timer_seconds == 6'd0 ? timer_minutes - 6'd1 : timer_minutes)
                      : (!at_max && timer_seconds == 6'd59 ? timer_minutes + 6'd1 : timer_minutes);
  assign game_state = state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (start) state_d = SERVE;
    else
      case (state)
        SERVE:   if (tick_1hz && serve_cnt == CW'(SERVE_TICKS - 1)) state_d = PLAY;
        PLAY:    state_d = pause_req ? PAUSED : over_ev ? OVER : pt ? SERVE : PLAY;
        PAUSED:  if (pause_req) state_d = PLAY;
        default: state_d = state;
      endcase
  end
  always_comb begin
    active_d = state_d == PLAY;
    over_d   = state_d == OVER;
    winner_d = s1_n > s2_n ? 2'b01 : s2_n > s1_n ? 2'b10 : 2'b11;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scoreP1       <= '0;
      scoreP2       <= '0;
      timer_minutes <= '0;
      timer_seconds <= '0;
      winner        <= '0;
      mode          <= 1'b0;
      serve_cnt     <= '0;
      game_active   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      game_active <= active_d;
      game_over   <= over_d;
      if (start) begin
        scoreP1       <= '0;
        scoreP2       <= '0;
        winner        <= '0;
        mode          <= mode_timed;
        timer_minutes <= mode_timed ? LOAD_MIN : 6'd0;
        timer_seconds <= mode_timed ? LOAD_SEC : 6'd0;
        serve_cnt     <= '0;
      end else begin
        if (pt) begin
          scoreP1 <= s1_n;
          scoreP2 <= s2_n;
        end
        if (tk) begin
          timer_minutes <= min_n;
          timer_seconds <= sec_n;
        end
        if (over_ev) winner <= winner_d;
        serve_cnt <= state == SERVE ? serve_cnt + CW'(tick_1hz) : '0;
      end
    end
endmodule
